prototype_trainer: RTL and testbench
====================================

# prototype_trainer

On-chip trainer that builds the class prototype hypervectors used by keyword inference. It accepts labelled training hypervectors and bundles them one class at a time into per-bit saturating counters. On the last sample of a class it binarizes the counters by majority and streams the prototype out fold by fold, with its class index, to the prototype store. It is the writer side of the prototype store that the inference associative memory reads.

## Interface
Parameters:
- `HV_DIMENSION`, 2000, hypervector width in bits; must equal `NUM_FOLDS*FOLD_WIDTH`.
- `NUM_FOLDS`, 10, folds per hypervector.
- `NUM_FOLDS_WIDTH`, 4, fold index width.
- `FOLD_WIDTH`, 200, bits processed per cycle.
- `COUNT_WIDTH`, 8, per-bit counter and sample-count width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `hvin_valid`  in  1  training sample valid.
- `hvin_ready`  out  1  trainer can accept a sample.
- `hvin`  in  HV_DIMENSION  training hypervector.
- `label`  in  4  class of `hvin`, 0..9.
- `last`  in  1  sample is the final one for its class.
- `dout_valid`  out  1  prototype fold valid.
- `dout_ready`  in  1  store accepts the fold.
- `dout_class`  out  4  class being emitted.
- `dout_fold`  out  NUM_FOLDS_WIDTH  fold index, 0..NUM_FOLDS-1.
- `dout_hv`  out  FOLD_WIDTH  prototype bits `[dout_fold*FOLD_WIDTH +: FOLD_WIDTH]`.
- `label_err`  out  1  sticky: a sample was dropped because of a label mismatch.
- `sat`  out  1  sticky: a sample was dropped because the sample count was saturated.

## Operation
- State machine with states IDLE, ACCUM and EMIT.
- **IDLE**
  - `hvin_ready`=1; no other state asserts it.
  - On a fire (`hvin_valid && hvin_ready`), latch `hvin`, `label` and `last`, and go to ACCUM with fold=0.
- **Class binding**
  - When `n`(sample count)==0, the latched label becomes the current class.
  - When `n`>0 and the label differs from the current class, drop the sample: no counter update and `n` unchanged. Set `label_err`. `last` is still honoured.
- **Saturation check**
  - When `n`==2^COUNT_WIDTH-1, drop the sample and set `sat`. `last` is still honoured.
- **ACCUM**
  - One fold per cycle, fold 0 first.
  - For a non-dropped sample, each counter in the fold increments when its `hvin` bit is 1. Counters saturate at 2^COUNT_WIDTH-1.
  - At fold NUM_FOLDS-1, increment `n` (non-dropped samples only).
  - Next state: EMIT if the latched `last`=1 and (`n`>0 after this sample), otherwise IDLE.
  - `last` on a sample that leaves `n`==0 returns to IDLE with no emission.
- **EMIT**
  - `dout_valid`=1, `dout_class`=current class, `dout_fold`=emit index.
  - `dout_hv[i]` = 1 iff 2*cnt > `n`, compared at COUNT_WIDTH+1 bits. Exact ties (2*cnt == `n`) resolve per Configuration.
  - `dout_hv` is combinational from registered counters and the emit index, so it stays stable while `dout_valid` is held.
  - Each `dout_fire` advances the emit index.
  - On `dout_fire` of fold NUM_FOLDS-1: clear all counters, set `n`=0 and emit index=0, and go to IDLE.
- `label_err` and `sat` clear only on `rst`.

## Timing
- Reset values:
  - Outputs: `dout_valid`=0, `dout_class`=0, `dout_fold`=0, `label_err`=0, `sat`=0. `hvin_ready`=1 in the cycle after `rst` deasserts.
  - Internal: all counters 0, `n`=0, state IDLE.
- **Reset mid-operation**: `rst` in ACCUM or EMIT aborts immediately. Partial prototypes are discarded and nothing further is emitted.
- **Per-sample cycles**: fire cycle, then exactly NUM_FOLDS ACCUM cycles.
  - `hvin_ready` is low for NUM_FOLDS cycles after each fire.
  - Maximum throughput is one sample per NUM_FOLDS+1 cycles.
- **Emit start**: `dout_valid` rises in the cycle after ACCUM fold NUM_FOLDS-1 of a `last` sample.
- **Emit length**: NUM_FOLDS cycles with no backpressure. Each cycle of `dout_ready`=0 holds all dout signals unchanged.
- **Return to IDLE**: `hvin_ready` returns the cycle after the final `dout_fire`.
- **Input behaviour while busy**: `hvin_valid` asserted while `hvin_ready`=0 is ignored and need not be held.

## Configuration
- `PROTOTYPE_TIE_RANDOM_EN` defined:
  - Tie bits take successive bits of a 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 on `rst`.
  - The LFSR advances one step per `dout_fire`.
  - Bit i of a fold uses LFSR bit (i mod 16).
- Undefined:
  - Ties resolve to 0. No LFSR is instantiated.

## Test plan
- **Majority**: class 3, three samples with fold-0 bit 0 = 1,1,0 and bit 1 = 0,0,1 (last on the third). Require fold 0 `dout_hv[1:0]`=2'b01, `dout_class`=3, `dout_fold` 0..9, `dout_valid` one cycle after the final ACCUM fold.
- **Ties, macro undefined**: two complementary samples of class 5. Require every `dout_hv` bit = 0. With the macro defined, fold 0 bits match LFSR bits of seed 16'hACE1.
- **Label mismatch**: class 2 sample, then a class 7 sample. Require `label_err`=1, `n`=1, and the emitted prototype equal to the first sample.
- **Backpressure**: `dout_ready` low for 5 cycles at fold 4. Require fold 4 and `dout_hv` held stable, emission completes with 10 fires, then `hvin_ready`=1.
- **Saturation**: with COUNT_WIDTH=2, send 4 all-ones samples of class 1. Require `sat`=1 after the 4th and an all-ones prototype.
- **Reset mid-EMIT**: assert `rst` at fold 6. Require `dout_valid`=0 next cycle, `hvin_ready`=1, and a subsequent single-sample class emitting exactly that sample.

Source files
------------

// File: rtl/prototype_trainer.sv
// prototype_trainer: bundles labelled training hypervectors into per-bit saturating counters and
// streams the majority-vote prototype fold by fold. Define PROTOTYPE_TIE_RANDOM_EN for LFSR tie-breaking.
module prototype_trainer #(
  parameter int HV_DIMENSION    = 2000,
  parameter int NUM_FOLDS       = 10,
  parameter int NUM_FOLDS_WIDTH = 4,
  parameter int FOLD_WIDTH      = 200,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hvin_valid,
  output logic                       hvin_ready,
  input  logic [HV_DIMENSION-1:0]    hvin,
  input  logic [3:0]                 label,
  input  logic                       last,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [3:0]                 dout_class,
  output logic [NUM_FOLDS_WIDTH-1:0] dout_fold,
  output logic [FOLD_WIDTH-1:0]      dout_hv,
  output logic                       label_err,
  output logic                       sat
);

  localparam int IDX_WIDTH = $clog2(HV_DIMENSION);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;
  state_t state;

  logic [COUNT_WIDTH-1:0]     cnt [HV_DIMENSION];
  logic [COUNT_WIDTH-1:0]     n;
  logic [HV_DIMENSION-1:0]    hv_q;
  logic                       last_q;
  logic                       drop_q;
  logic [NUM_FOLDS_WIDTH-1:0] fold;
  logic [IDX_WIDTH-1:0]       accum_base;
  logic [IDX_WIDTH-1:0]       emit_base;
  logic [COUNT_WIDTH:0]       n_ext;
  logic [COUNT_WIDTH:0]       twice;

  assign accum_base = IDX_WIDTH'(int'(fold) * FOLD_WIDTH);
  assign emit_base  = IDX_WIDTH'(int'(dout_fold) * FOLD_WIDTH);
  assign n_ext      = {1'b0, n};

`ifdef PROTOTYPE_TIE_RANDOM_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR (taps 16,14,13,11), one step per accepted prototype fold
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else if (dout_valid && dout_ready) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`endif

  // Majority vote at COUNT_WIDTH+1 bits so 2*cnt never overflows
  always_comb begin
    dout_hv = '0;
    twice   = '0;
    for (int i = 0; i < FOLD_WIDTH; i++) begin
      twice = {cnt[emit_base + IDX_WIDTH'(i)], 1'b0};
      if (twice > n_ext) dout_hv[i] = 1'b1;
`ifdef PROTOTYPE_TIE_RANDOM_EN
      else if (twice == n_ext) dout_hv[i] = lfsr[4'(i)];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hvin_ready <= 1'b1;
      dout_valid <= 1'b0;
      dout_class <= '0;
      dout_fold  <= '0;
      fold       <= '0;
      n          <= '0;
      hv_q       <= '0;
      last_q     <= 1'b0;
      drop_q     <= 1'b0;
      label_err  <= 1'b0;
      sat        <= 1'b0;
      for (int i = 0; i < HV_DIMENSION; i++) cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hvin_valid && hvin_ready) begin
            hv_q       <= hvin;
            last_q     <= last;
            fold       <= '0;
            hvin_ready <= 1'b0;
            state      <= ACCUM;
            // The drop decision is made once per sample, against the class bound so far
            if (n == '0) begin
              dout_class <= label;
              drop_q     <= 1'b0;
            end else begin
              drop_q <= (label != dout_class) || (n == CNT_MAX);
              if (label != dout_class) label_err <= 1'b1;
              if (n == CNT_MAX) sat <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (!drop_q) begin
            for (int i = 0; i < FOLD_WIDTH; i++) begin
              if (hv_q[accum_base + IDX_WIDTH'(i)] && cnt[accum_base + IDX_WIDTH'(i)] != CNT_MAX)
                cnt[accum_base + IDX_WIDTH'(i)] <= cnt[accum_base + IDX_WIDTH'(i)] + COUNT_WIDTH'(1);
            end
          end
          if (fold == LAST_FOLD) begin
            fold <= '0;
            if (!drop_q) n <= n + COUNT_WIDTH'(1);
            if (last_q && (n != '0 || !drop_q)) begin
              state      <= EMIT;
              dout_valid <= 1'b1;
            end else begin
              state      <= IDLE;
              hvin_ready <= 1'b1;
            end
          end else begin
            fold <= fold + NUM_FOLDS_WIDTH'(1);
          end
        end
        EMIT: begin
          if (dout_ready) begin
            if (dout_fold == LAST_FOLD) begin
              for (int i = 0; i < HV_DIMENSION; i++) cnt[i] <= '0;
              n          <= '0;
              dout_fold  <= '0;
              dout_valid <= 1'b0;
              hvin_ready <= 1'b1;
              state      <= IDLE;
            end else begin
              dout_fold <= dout_fold + NUM_FOLDS_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prototype_trainer.sv
// tb_prototype_trainer: randomized bench for prototype_trainer against a sample-list majority model.
// A second instance with COUNT_WIDTH=2 covers sample-count saturation.
module tb_prototype_trainer;

  localparam int HV   = 2000;
  localparam int NF   = 10;
  localparam int FW   = 200;
  localparam int MAXN = 255;

  logic clk, rst;
  logic hvin_valid, hvin_ready, last, dout_valid, dout_ready, label_err, sat;
  logic [HV-1:0] hvin;
  logic [3:0] label, dout_class;
  logic [3:0] dout_fold;
  logic [FW-1:0] dout_hv;

  logic s_hvin_valid, s_hvin_ready, s_last, s_dout_valid, s_dout_ready, s_label_err, s_sat;
  logic [HV-1:0] s_hvin;
  logic [3:0] s_label, s_dout_class;
  logic [3:0] s_dout_fold;
  logic [FW-1:0] s_dout_hv;

  int checks = 0;
  int passes = 0;

  logic [HV-1:0] acc_q[$];
  logic [3:0] m_class;
  logic m_label_err;
  logic [15:0] m_lfsr;

  logic [HV-1:0] got_proto;
  logic [3:0] got_class;
  int got_fold[NF];
  int got_wait;
  logic got_timeout, got_ready_after, got_valid_after;

  prototype_trainer dut (
    .clk(clk), .rst(rst), .hvin_valid(hvin_valid), .hvin_ready(hvin_ready), .hvin(hvin),
    .label(label), .last(last), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_class(dout_class), .dout_fold(dout_fold), .dout_hv(dout_hv),
    .label_err(label_err), .sat(sat)
  );

  prototype_trainer #(.COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .hvin_valid(s_hvin_valid), .hvin_ready(s_hvin_ready), .hvin(s_hvin),
    .label(s_label), .last(s_last), .dout_valid(s_dout_valid), .dout_ready(s_dout_ready),
    .dout_class(s_dout_class), .dout_fold(s_dout_fold), .dout_hv(s_dout_hv),
    .label_err(s_label_err), .sat(s_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [HV-1:0] rand_hv();
    logic [HV-1:0] v;
    for (int k = 0; k < HV; k++) v[k] = 1'($urandom);
    return v;
  endfunction

  function automatic int first_diff(input logic [HV-1:0] a, input logic [HV-1:0] b);
    for (int k = 0; k < HV; k++) if (a[k] !== b[k]) return k;
    return -1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Prototype = per-bit majority over the accepted sample list
  function automatic logic [HV-1:0] expected_proto();
    logic [HV-1:0] e;
    int ones, n;
`ifdef PROTOTYPE_TIE_RANDOM_EN
    logic [15:0] l;
    l = m_lfsr;
`endif
    e = '0;
    n = acc_q.size();
    for (int f = 0; f < NF; f++) begin
      for (int j = 0; j < FW; j++) begin
        ones = 0;
        foreach (acc_q[k]) ones += int'(acc_q[k][f*FW+j]);
        if (ones > MAXN) ones = MAXN;
        if (2 * ones > n) e[f*FW+j] = 1'b1;
`ifdef PROTOTYPE_TIE_RANDOM_EN
        else if (2 * ones == n) e[f*FW+j] = l[j % 16];
`endif
      end
`ifdef PROTOTYPE_TIE_RANDOM_EN
      l = lfsr_step(l);
`endif
    end
    return e;
  endfunction

  task automatic model_reset();
    acc_q.delete();
    m_class = 4'd0;
    m_label_err = 1'b0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_send(input logic [HV-1:0] hv, input logic [3:0] lab);
    if (acc_q.size() == 0) begin
      m_class = lab;
      acc_q.push_back(hv);
    end else if (lab != m_class) begin
      m_label_err = 1'b1;
    end else if (acc_q.size() < MAXN) begin
      acc_q.push_back(hv);
    end
  endtask

  task automatic model_finish_emit();
    acc_q.delete();
    for (int k = 0; k < NF; k++) m_lfsr = lfsr_step(m_lfsr);
  endtask

  // One fire, then garbage on the input bus during the ACCUM cycles
  task automatic send_sample(input logic [HV-1:0] hv, input logic [3:0] lab, input logic lst);
    int w;
    w = 0;
    while (!hvin_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (hvin_ready !== 1'b1) $display("[TB] FAIL send ready: hvin_ready=%b want 1", hvin_ready);
    else passes++;
    hvin = hv; label = lab; last = lst; hvin_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < NF; k++) begin
      hvin_valid = 1'($urandom);
      hvin = rand_hv();
      label = 4'($urandom_range(0, 9));
      last = 1'($urandom);
      @(posedge clk); #1;
    end
    hvin_valid = 1'b0;
  endtask

  task automatic train(input logic [HV-1:0] hv, input logic [3:0] lab, input logic lst);
    model_send(hv, lab);
    send_sample(hv, lab, lst);
  endtask

  task automatic receive_emit();
    got_wait = 0;
    while (!dout_valid && got_wait < 50) begin
      @(posedge clk); #1; got_wait++;
    end
    got_timeout = !dout_valid;
    got_class = dout_class;
    if (!got_timeout) begin
      for (int f = 0; f < NF; f++) begin
        got_fold[f] = int'(dout_fold);
        got_proto[f*FW +: FW] = dout_hv;
        dout_ready = 1'b1;
        @(posedge clk); #1;
      end
    end
    dout_ready = 1'b0;
    got_ready_after = hvin_ready;
    got_valid_after = dout_valid;
    model_finish_emit();
  endtask

  task automatic test_reset();
    rst = 1'b1; hvin_valid = 1'b0; dout_ready = 1'b0; hvin = '0; label = '0; last = 1'b0;
    s_hvin_valid = 1'b0; s_dout_ready = 1'b0; s_hvin = '0; s_label = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++; if (dout_valid !== 1'b0) $display("[TB] FAIL reset dout_valid: got %b want 0", dout_valid); else passes++;
    checks++; if (dout_class !== 4'd0) $display("[TB] FAIL reset dout_class: got %0d want 0", dout_class); else passes++;
    checks++; if (dout_fold !== 4'd0) $display("[TB] FAIL reset dout_fold: got %0d want 0", dout_fold); else passes++;
    checks++; if (label_err !== 1'b0) $display("[TB] FAIL reset label_err: got %b want 0", label_err); else passes++;
    checks++; if (sat !== 1'b0) $display("[TB] FAIL reset sat: got %b want 0", sat); else passes++;
    checks++; if (hvin_ready !== 1'b1) $display("[TB] FAIL reset hvin_ready: got %b want 1", hvin_ready); else passes++;
    checks++; if (s_sat !== 1'b0) $display("[TB] FAIL reset sat (small): got %b want 0", s_sat); else passes++;
  endtask

  task automatic test_majority();
    logic [HV-1:0] h0, h1, h2, exp;
    h0 = rand_hv(); h0[1:0] = 2'b01;
    h1 = rand_hv(); h1[1:0] = 2'b01;
    h2 = rand_hv(); h2[1:0] = 2'b10;
    train(h0, 4'd3, 1'b0);
    train(h1, 4'd3, 1'b0);
    train(h2, 4'd3, 1'b1);
    exp = expected_proto();
    receive_emit();
    checks++; if (got_wait !== 0 || got_timeout) $display("[TB] FAIL majority valid latency: waited %0d cycles want 0", got_wait); else passes++;
    checks++; if (got_class !== 4'd3) $display("[TB] FAIL majority class: got %0d want 3", got_class); else passes++;
    checks++; if (got_proto[1:0] !== 2'b01) $display("[TB] FAIL majority bits: got %b want 01", got_proto[1:0]); else passes++;
    checks++; if (got_proto !== exp) $display("[TB] FAIL majority proto: first diff bit %0d", first_diff(got_proto, exp)); else passes++;
    for (int f = 0; f < NF; f++) begin
      checks++; if (got_fold[f] !== f) $display("[TB] FAIL majority fold index: got %0d want %0d", got_fold[f], f); else passes++;
    end
    checks++; if (got_ready_after !== 1'b1 || got_valid_after !== 1'b0) $display("[TB] FAIL majority end: ready=%b valid=%b want 1/0", got_ready_after, got_valid_after); else passes++;
  endtask

  task automatic test_ties();
    logic [HV-1:0] a, exp;
    a = rand_hv();
    train(a, 4'd5, 1'b0);
    train(~a, 4'd5, 1'b1);
    exp = expected_proto();
    receive_emit();
    checks++; if (got_class !== 4'd5) $display("[TB] FAIL ties class: got %0d want 5", got_class); else passes++;
    checks++; if (got_proto !== exp) $display("[TB] FAIL ties proto: first diff bit %0d", first_diff(got_proto, exp)); else passes++;
`ifndef PROTOTYPE_TIE_RANDOM_EN
    checks++; if (got_proto !== '0) $display("[TB] FAIL ties zero: first set bit %0d want none", first_diff(got_proto, '0)); else passes++;
`endif
  endtask

  task automatic test_label_mismatch();
    logic [HV-1:0] a, b, exp;
    a = rand_hv(); b = rand_hv();
    train(a, 4'd2, 1'b0);
    train(b, 4'd7, 1'b1);
    exp = expected_proto();
    checks++; if (label_err !== 1'b1) $display("[TB] FAIL mismatch label_err: got %b want 1", label_err); else passes++;
    receive_emit();
    checks++; if (got_class !== 4'd2) $display("[TB] FAIL mismatch class: got %0d want 2", got_class); else passes++;
    checks++; if (got_proto !== a) $display("[TB] FAIL mismatch proto: first diff bit %0d", first_diff(got_proto, a)); else passes++;
    checks++; if (got_proto !== exp) $display("[TB] FAIL mismatch model: first diff bit %0d", first_diff(got_proto, exp)); else passes++;
  endtask

  task automatic test_backpressure();
    logic [HV-1:0] exp;
    logic [FW-1:0] held;
    logic [3:0] cls;
    int fires, stall, cycles;
    cls = 4'($urandom_range(0, 9));
    for (int s = 0; s < 3; s++) train(rand_hv(), cls, s == 2);
    exp = expected_proto();
    fires = 0; stall = 0; cycles = 0; held = '0;
    while (fires < NF && cycles < 60) begin
      if (dout_valid && dout_fold == 4'd4 && stall < 5) begin
        if (stall == 0) held = dout_hv;
        else begin
          checks++;
          if (dout_fold !== 4'd4 || dout_hv !== held || dout_valid !== 1'b1)
            $display("[TB] FAIL backpressure hold: fold=%0d valid=%b hv_same=%b want 4/1/1", dout_fold, dout_valid, dout_hv === held);
          else passes++;
        end
        dout_ready = 1'b0;
        stall++;
      end else begin
        dout_ready = 1'b1;
        if (dout_valid) begin
          got_proto[int'(dout_fold)*FW +: FW] = dout_hv;
          fires++;
        end
      end
      @(posedge clk); #1; cycles++;
    end
    dout_ready = 1'b0;
    model_finish_emit();
    checks++; if (fires !== NF || cycles !== NF + 5) $display("[TB] FAIL backpressure fires: got %0d fires in %0d cycles want 10 in 15", fires, cycles); else passes++;
    checks++; if (hvin_ready !== 1'b1) $display("[TB] FAIL backpressure ready: got %b want 1", hvin_ready); else passes++;
    checks++; if (got_proto !== exp) $display("[TB] FAIL backpressure proto: first diff bit %0d", first_diff(got_proto, exp)); else passes++;
  endtask

  task automatic test_saturation();
    logic [HV-1:0] proto;
    int w;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!s_hvin_ready && w < 100) begin
        @(posedge clk); #1; w++;
      end
      s_hvin = '1; s_label = 4'd1; s_last = (k == 3); s_hvin_valid = 1'b1;
      @(posedge clk); #1;
      s_hvin_valid = 1'b0;
      repeat (NF) @(posedge clk);
      #1;
      if (k == 2) begin
        checks++; if (s_sat !== 1'b0) $display("[TB] FAIL saturation early sat: got %b want 0", s_sat); else passes++;
      end
    end
    checks++; if (s_sat !== 1'b1) $display("[TB] FAIL saturation sat: got %b want 1", s_sat); else passes++;
    checks++; if (s_dout_valid !== 1'b1 || s_dout_class !== 4'd1) $display("[TB] FAIL saturation emit: valid=%b class=%0d want 1/1", s_dout_valid, s_dout_class); else passes++;
    proto = '0;
    for (int f = 0; f < NF; f++) begin
      proto[int'(s_dout_fold)*FW +: FW] = s_dout_hv;
      s_dout_ready = 1'b1;
      @(posedge clk); #1;
    end
    s_dout_ready = 1'b0;
    checks++; if (proto !== '1) $display("[TB] FAIL saturation proto: first zero bit %0d want none", first_diff(proto, '1)); else passes++;
    checks++; if (s_hvin_ready !== 1'b1) $display("[TB] FAIL saturation ready: got %b want 1", s_hvin_ready); else passes++;
  endtask

  task automatic test_reset_mid_emit();
    logic [HV-1:0] a;
    logic [3:0] cls;
    train(rand_hv(), 4'd8, 1'b1);
    for (int f = 0; f < 6; f++) begin
      dout_ready = 1'b1;
      @(posedge clk); #1;
    end
    dout_ready = 1'b0;
    checks++; if (dout_fold !== 4'd6) $display("[TB] FAIL midreset fold: got %0d want 6", dout_fold); else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (dout_valid !== 1'b0 || hvin_ready !== 1'b1) $display("[TB] FAIL midreset abort: valid=%b ready=%b want 0/1", dout_valid, hvin_ready); else passes++;
    rst = 1'b0;
    model_reset();
    a = rand_hv();
    cls = 4'($urandom_range(0, 9));
    train(a, cls, 1'b1);
    receive_emit();
    checks++; if (got_class !== cls) $display("[TB] FAIL midreset class: got %0d want %0d", got_class, cls); else passes++;
    checks++; if (got_proto !== a) $display("[TB] FAIL midreset proto: first diff bit %0d", first_diff(got_proto, a)); else passes++;
    checks++; if (label_err !== 1'b0 || sat !== 1'b0) $display("[TB] FAIL midreset flags: label_err=%b sat=%b want 0/0", label_err, sat); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [HV-1:0] exp;
    logic [3:0] cls, lab;
    int ns;
    for (int r = 0; r < 6; r++) begin
      cls = 4'($urandom_range(0, 9));
      ns = $urandom_range(1, 4);
      for (int s = 0; s < ns; s++) begin
        lab = (s > 0 && $urandom_range(0, 3) == 0) ? 4'((int'(cls) + 1) % 10) : cls;
        train(rand_hv(), lab, s == ns - 1);
      end
      exp = expected_proto();
      receive_emit();
      checks++; if (got_wait !== 0 || got_timeout) $display("[TB] FAIL random latency: waited %0d want 0", got_wait); else passes++;
      checks++; if (got_class !== cls) $display("[TB] FAIL random class: got %0d want %0d", got_class, cls); else passes++;
      checks++; if (got_proto !== exp) $display("[TB] FAIL random proto: first diff bit %0d", first_diff(got_proto, exp)); else passes++;
      checks++; if (label_err !== m_label_err) $display("[TB] FAIL random label_err: got %b want %b", label_err, m_label_err); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_majority();
    test_ties();
    test_label_mismatch();
    test_backpressure();
    test_saturation();
    test_reset_mid_emit();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
